// File: rtl/actuator_arbiter.sv
// Fixed-priority arbiter (alarm > manual > occupancy) for the curtain motor command and the light PWM duty.
// Define ACTUATOR_ARBITER_DEADTIME_EN to add a stop interval between opposite motor directions.
module actuator_arbiter #(
    parameter int DEAD_CYCLES = 50_000,
    parameter int HOLD_CYCLES = 25_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        req_a,
    input  logic        req_m,
    input  logic        req_o,
    input  logic [1:0]  accion_a,
    input  logic [1:0]  accion_m,
    input  logic [1:0]  accion_o,
    input  logic [15:0] dutty_a,
    input  logic [15:0] dutty_m,
    input  logic [15:0] dutty_o,
    output logic [1:0]  accion,
    output logic [15:0] dutty,
    output logic [2:0]  grant,
    output logic        dead
);

`ifdef ACTUATOR_ARBITER_DEADTIME_EN
    typedef enum logic [1:0] {S_IDLE, S_GRANT, S_DEAD} state_t;
    localparam int DCW = (DEAD_CYCLES > 2) ? $clog2(DEAD_CYCLES) : 1;
    logic [DCW-1:0] r_dead_cnt, w_cnt_next;
`else
    typedef enum logic [1:0] {S_IDLE, S_GRANT} state_t;
    logic w_unused_cfg;
    assign w_unused_cfg = (DEAD_CYCLES == 0);
`endif

    state_t      r_state, w_state_next;
    logic [2:0]  r_grant, w_grant_next, w_new_grant, w_pick, w_req;
    logic [1:0]  r_accion, w_accion_next, w_cand_act;
    logic [15:0] r_dutty, w_dutty_next, w_cand_duty;
    logic [25:0] r_hold, w_hold_next, w_hold_inc;
    logic        w_hold_done, w_owner_req, w_new_req;

    // Requested action for a one-hot owner; the undefined code 11 means stop.
    function automatic logic [1:0] f_act(input logic [2:0] g, input logic [1:0] a,
                                         input logic [1:0] m, input logic [1:0] o);
        logic [1:0] v;
        v = 2'b00;
        case (g)
            3'b100:  v = a;
            3'b010:  v = m;
            3'b001:  v = o;
            default: v = 2'b00;
        endcase
        return (v == 2'b11) ? 2'b00 : v;
    endfunction

    function automatic logic [15:0] f_duty(input logic [2:0] g, input logic [15:0] a,
                                           input logic [15:0] m, input logic [15:0] o);
        logic [15:0] v;
        v = 16'h0000;
        case (g)
            3'b100:  v = a;
            3'b010:  v = m;
            3'b001:  v = o;
            default: v = 16'h0000;
        endcase
        return v;
    endfunction

    assign w_req       = {req_a, req_m, req_o};
    assign w_pick      = req_a ? 3'b100 : (req_m ? 3'b010 : (req_o ? 3'b001 : 3'b000));
    assign w_hold_done = (r_hold >= 26'(HOLD_CYCLES));
    assign w_hold_inc  = (&r_hold) ? r_hold : r_hold + 26'd1;
    assign w_owner_req = |(r_grant & w_req);

    always_comb begin
        w_state_next  = r_state;
        w_grant_next  = r_grant;
        w_accion_next = r_accion;
        w_dutty_next  = r_dutty;
        w_hold_next   = w_hold_inc;
`ifdef ACTUATOR_ARBITER_DEADTIME_EN
        w_cnt_next    = r_dead_cnt;
`endif
        // Owner for the next cycle; only alarm may take over while the stop interval runs.
        w_new_grant = r_grant;
        if (req_a && r_grant != 3'b100)
            w_new_grant = 3'b100;
        else if (r_state == S_GRANT && !w_owner_req && w_hold_done)
            w_new_grant = w_pick;
        else if (r_state == S_GRANT && r_grant == 3'b001 && req_m && w_hold_done)
            w_new_grant = 3'b010;

        // A silent owner still inside its hold window keeps its last registered values.
        w_new_req   = |(w_new_grant & w_req);
        w_cand_act  = w_new_req ? f_act(w_new_grant, accion_a, accion_m, accion_o) : r_accion;
        w_cand_duty = w_new_req ? f_duty(w_new_grant, dutty_a, dutty_m, dutty_o) : r_dutty;

        case (r_state)
            S_IDLE: begin
                w_hold_next = '0;
                if (|w_req) begin
                    w_state_next  = S_GRANT;
                    w_grant_next  = w_pick;
                    w_accion_next = f_act(w_pick, accion_a, accion_m, accion_o);
                    w_dutty_next  = f_duty(w_pick, dutty_a, dutty_m, dutty_o);
                end
            end
            S_GRANT: begin
                if (w_new_grant != r_grant)
                    w_hold_next = '0;
                if (w_new_grant == 3'b000) begin
                    w_state_next  = S_IDLE;
                    w_grant_next  = 3'b000;
                    w_accion_next = 2'b00;
                    w_dutty_next  = 16'h0000;
                end else begin
                    w_grant_next  = w_new_grant;
                    w_dutty_next  = w_cand_duty;
                    w_accion_next = w_cand_act;
`ifdef ACTUATOR_ARBITER_DEADTIME_EN
                    if ((r_accion ^ w_cand_act) == 2'b11) begin
                        w_state_next  = S_DEAD;
                        w_accion_next = 2'b00;
                        w_cnt_next    = '0;
                    end
`endif
                end
            end
`ifdef ACTUATOR_ARBITER_DEADTIME_EN
            S_DEAD: begin
                if (w_new_grant != r_grant)
                    w_hold_next = '0;
                w_grant_next  = w_new_grant;
                w_dutty_next  = w_cand_duty;
                w_accion_next = 2'b00;
                if (r_dead_cnt == DCW'(DEAD_CYCLES - 1)) begin
                    w_state_next  = S_GRANT;
                    w_accion_next = w_new_req ? f_act(w_new_grant, accion_a, accion_m, accion_o)
                                              : 2'b00;
                end else begin
                    w_cnt_next = r_dead_cnt + DCW'(1);
                end
            end
`endif
            default: w_state_next = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state  <= S_IDLE;
            r_grant  <= 3'b000;
            r_accion <= 2'b00;
            r_dutty  <= 16'h0000;
            r_hold   <= '0;
        end else begin
            r_state  <= w_state_next;
            r_grant  <= w_grant_next;
            r_accion <= w_accion_next;
            r_dutty  <= w_dutty_next;
            r_hold   <= w_hold_next;
        end
    end

`ifdef ACTUATOR_ARBITER_DEADTIME_EN
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            r_dead_cnt <= '0;
        else
            r_dead_cnt <= w_cnt_next;
    end
    assign dead = (r_state == S_DEAD);
`else
    assign dead = 1'b0;
`endif

    assign accion = r_accion;
    assign dutty  = r_dutty;
    assign grant  = r_grant;

endmodule
